// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge port between the MEM-stage controller and the memory.
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumes the EX/MEM register, runs multi-cycle data-memory
// accesses over a req/ack port, stalls the upstream pipeline while an access is in
// flight and loads the MEM/WB register.
//
// state | meaning
// IDLE  | accepting the EX/MEM instruction; non-memory ops go straight to WB
// BUSY  | request outstanding, waiting for ack or timeout
// DONE  | access finished; WB loads the latched result on the next edge
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [4:0]  writeregM,
  input  logic [31:0] instrM,
  mem_stage_ctrl_if.master dmem,
  output logic        stallM,
  output logic        regwriteW,
  output logic        memtoregW,
  output logic [31:0] readdataW,
  output logic [31:0] aluoutW,
  output logic [4:0]  writeregW,
  output logic [31:0] instrW,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           nonmem, aligned;
  logic           issue, misalign, got_ack, timed_out;
  logic           lat_regwrite, lat_load, lat_store, lat_to;
  logic [31:0]    lat_aluout, lat_instr, lat_rdata;
  logic [4:0]     lat_writereg;

  // An unknown op flag falls through to the memory-op branch.
  assign nonmem  = ~memtoregM & ~memwriteM;
  assign aligned = (aluoutM[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, stall and per-cycle control strobes.
  always_comb begin
    state_nx  = state;
    stallM    = 1'b0;
    issue     = 1'b0;
    misalign  = 1'b0;
    got_ack   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (nonmem) begin
          state_nx = IDLE;
        end else if (aligned) begin
          stallM   = 1'b1;
          issue    = 1'b1;
          state_nx = BUSY;
        end else begin
          misalign = 1'b1;
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (dmem.dmem_ack) begin
          got_ack  = 1'b1;
          state_nx = DONE;
        end else if (cnt == '0) begin
          timed_out = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      state_nx  = IDLE;
      stallM    = 1'b0;
      issue     = 1'b0;
      misalign  = 1'b0;
      got_ack   = 1'b0;
      timed_out = 1'b0;
    end
  end

  // Memory port, wait counter, latched M fields and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      cnt             <= '0;
      lat_regwrite    <= 1'b0;
      lat_load        <= 1'b0;
      lat_store       <= 1'b0;
      lat_to          <= 1'b0;
      lat_aluout      <= '0;
      lat_instr       <= '0;
      lat_rdata       <= '0;
      lat_writereg    <= '0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign_err <= misalign;
      if (timed_out) bus_err <= 1'b1;
      if (issue) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= memwriteM;
        dmem.dmem_addr  <= aluoutM;
        dmem.dmem_wdata <= writedataM;
        cnt             <= CW'(TIMEOUT - 1);
        lat_regwrite    <= regwriteM;
        lat_load        <= memtoregM & ~memwriteM;
        lat_store       <= memwriteM;
        lat_to          <= 1'b0;
        lat_aluout      <= aluoutM;
        lat_instr       <= instrM;
        lat_rdata       <= '0;
        lat_writereg    <= writeregM;
      end else if (got_ack) begin
        dmem.dmem_req <= 1'b0;
        if (lat_load) lat_rdata <= dmem.dmem_rdata;
      end else if (timed_out) begin
        dmem.dmem_req <= 1'b0;
        lat_to        <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // MEM/WB register: M fields, latched access result, or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      readdataW <= '0;
      aluoutW   <= '0;
      writeregW <= '0;
      instrW    <= '0;
    end else if (state == IDLE && nonmem) begin
      regwriteW <= regwriteM;
      memtoregW <= 1'b0;
      readdataW <= '0;
      aluoutW   <= aluoutM;
      writeregW <= writeregM;
      instrW    <= instrM;
    end else if (misalign) begin
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      readdataW <= '0;
      aluoutW   <= '0;
      writeregW <= '0;
      instrW    <= instrM;
    end else if (state == DONE) begin
      regwriteW <= lat_regwrite & ~lat_store & ~lat_to;
      memtoregW <= lat_load & ~lat_to;
      readdataW <= (lat_load && !lat_to) ? lat_rdata : '0;
      aluoutW   <= lat_aluout;
      writeregW <= lat_to ? 5'd0 : lat_writereg;
      instrW    <= lat_instr;
    end else begin
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      readdataW <= '0;
      aluoutW   <= '0;
      writeregW <= '0;
      instrW    <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: a table of instructions is turned into a per-cycle
// timeline of expected outputs from the access latency rules, the DUT is driven from
// that timeline and compared every cycle, then a mid-access reset is exercised.
module tb_mem_stage_ctrl;

  localparam int TO = 4;
  localparam int NC = 64;
  localparam int NOPS = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regwriteM = 0, memtoregM = 0, memwriteM = 0;
  logic [31:0] aluoutM = 0, writedataM = 0, instrM = 0;
  logic [4:0]  writeregM = 0;
  logic        stallM, regwriteW, memtoregW, misalign_err, bus_err;
  logic [31:0] readdataW, aluoutW, instrW;
  logic [4:0]  writeregW;

  mem_stage_ctrl_if dmem_if ();

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM), .instrM(instrM),
    .dmem(dmem_if),
    .stallM(stallM), .regwriteW(regwriteW), .memtoregW(memtoregW),
    .readdataW(readdataW), .aluoutW(aluoutW), .writeregW(writeregW), .instrW(instrW),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw, mtr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic [31:0] instr;
    int          ack_at;   // BUSY cycle carrying the ack, 0 = never
    logic [31:0] rdata;
    int          stray;    // cycle offset of an ack while no request is out, -1 = none
  } op_t;

  op_t ops [NOPS];

  // per-cycle stimulus
  logic        in_rw [NC], in_mtr [NC], in_mw [NC], in_ack [NC];
  logic [31:0] in_alu [NC], in_wd [NC], in_instr [NC], in_rdata [NC];
  logic [4:0]  in_wr [NC];
  // per-cycle expectations
  logic        e_stall [NC], e_req [NC], e_we [NC], e_mis [NC], e_bus [NC];
  logic [31:0] e_addr [NC], e_wdata [NC];
  logic        e_rw [NC], e_mtr [NC];
  logic [31:0] e_rd [NC], e_alu [NC], e_instr [NC];
  logic [4:0]  e_wr [NC];
  // observed values kept for the literal spot checks
  logic        o_stall [NC], o_req [NC], o_mis [NC], o_bus [NC], o_rw [NC], o_mtr [NC];
  logic [31:0] o_rd [NC], o_alu [NC];
  int ncyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic rw, input logic mtr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                        input logic [31:0] instr, input int ack_at, input logic [31:0] rdata,
                        input int stray);
    ops[i].rw = rw; ops[i].mtr = mtr; ops[i].mw = mw; ops[i].alu = alu; ops[i].wd = wd;
    ops[i].wr = wr; ops[i].instr = instr; ops[i].ack_at = ack_at; ops[i].rdata = rdata;
    ops[i].stray = stray;
  endtask

  // Lay the instruction table out on a cycle timeline using the latency rules:
  // non-memory or misaligned ops take one cycle; an aligned access with its answer
  // (ack or timeout) in BUSY cycle N occupies N+2 cycles and reaches WB after them.
  task automatic build_model();
    int t, n, dur, bus_from;
    bus_from = NC;
    for (int c = 0; c < NC; c++) begin
      in_rw[c] = 0; in_mtr[c] = 0; in_mw[c] = 0; in_ack[c] = 0;
      in_alu[c] = 0; in_wd[c] = 0; in_instr[c] = 0; in_wr[c] = 0;
      in_rdata[c] = 32'hBAD0_0000 | 32'(c);
      e_stall[c] = 0; e_req[c] = 0; e_we[c] = 0; e_mis[c] = 0; e_bus[c] = 0;
      e_addr[c] = 0; e_wdata[c] = 0;
      e_rw[c] = 0; e_mtr[c] = 0; e_rd[c] = 0; e_alu[c] = 0; e_instr[c] = 0; e_wr[c] = 0;
    end
    t = 0;
    for (int i = 0; i < NOPS; i++) begin
      if (!ops[i].mtr && !ops[i].mw) begin
        dur = 1;
        e_rw[t+1] = ops[i].rw; e_alu[t+1] = ops[i].alu;
        e_wr[t+1] = ops[i].wr; e_instr[t+1] = ops[i].instr;
      end else if (ops[i].alu[1:0] != 2'b00) begin
        dur = 1;
        e_mis[t+1] = 1; e_instr[t+1] = ops[i].instr;
      end else begin
        n = (ops[i].ack_at > 0) ? ops[i].ack_at : TO;
        dur = n + 2;
        for (int k = t; k <= t + n; k++) e_stall[k] = 1;
        for (int k = t + 1; k <= t + n; k++) begin
          e_req[k] = 1; e_we[k] = ops[i].mw; e_addr[k] = ops[i].alu; e_wdata[k] = ops[i].wd;
        end
        e_alu[t+n+2] = ops[i].alu; e_instr[t+n+2] = ops[i].instr;
        if (ops[i].ack_at > 0) begin
          in_ack[t+n] = 1; in_rdata[t+n] = ops[i].rdata;
          e_wr[t+n+2] = ops[i].wr;
          if (!ops[i].mw) begin
            e_rw[t+n+2] = ops[i].rw; e_mtr[t+n+2] = 1; e_rd[t+n+2] = ops[i].rdata;
          end
        end else if (t + n + 1 < bus_from) begin
          bus_from = t + n + 1;
        end
      end
      for (int k = t; k < t + dur; k++) begin
        in_rw[k] = ops[i].rw; in_mtr[k] = ops[i].mtr; in_mw[k] = ops[i].mw;
        in_alu[k] = ops[i].alu; in_wd[k] = ops[i].wd; in_wr[k] = ops[i].wr;
        in_instr[k] = ops[i].instr;
      end
      if (ops[i].stray >= 0) in_ack[t + ops[i].stray] = 1;
      t += dur;
    end
    ncyc = t + 4;
    for (int c = bus_from; c < NC; c++) e_bus[c] = 1;
  endtask

  task automatic apply(input int c);
    regwriteM = in_rw[c]; memtoregM = in_mtr[c]; memwriteM = in_mw[c];
    aluoutM = in_alu[c]; writedataM = in_wd[c]; writeregM = in_wr[c]; instrM = in_instr[c];
    dmem_if.dmem_ack = in_ack[c]; dmem_if.dmem_rdata = in_rdata[c];
  endtask

  task automatic check_cycle(input int c);
    chk($sformatf("c%0d stallM", c), 32'(stallM), 32'(e_stall[c]));
    chk($sformatf("c%0d dmem_req", c), 32'(dmem_if.dmem_req), 32'(e_req[c]));
    if (e_req[c]) begin
      chk($sformatf("c%0d dmem_we", c), 32'(dmem_if.dmem_we), 32'(e_we[c]));
      chk($sformatf("c%0d dmem_addr", c), dmem_if.dmem_addr, e_addr[c]);
      chk($sformatf("c%0d dmem_wdata", c), dmem_if.dmem_wdata, e_wdata[c]);
    end
    chk($sformatf("c%0d misalign_err", c), 32'(misalign_err), 32'(e_mis[c]));
    chk($sformatf("c%0d bus_err", c), 32'(bus_err), 32'(e_bus[c]));
    chk($sformatf("c%0d regwriteW", c), 32'(regwriteW), 32'(e_rw[c]));
    chk($sformatf("c%0d memtoregW", c), 32'(memtoregW), 32'(e_mtr[c]));
    chk($sformatf("c%0d readdataW", c), readdataW, e_rd[c]);
    chk($sformatf("c%0d aluoutW", c), aluoutW, e_alu[c]);
    chk($sformatf("c%0d writeregW", c), 32'(writeregW), 32'(e_wr[c]));
    chk($sformatf("c%0d instrW", c), instrW, e_instr[c]);
    o_stall[c] = stallM; o_req[c] = dmem_if.dmem_req; o_mis[c] = misalign_err;
    o_bus[c] = bus_err; o_rw[c] = regwriteW; o_mtr[c] = memtoregW;
    o_rd[c] = readdataW; o_alu[c] = aluoutW;
  endtask

  function automatic int count_hi(input logic v [NC], input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += int'(v[c]);
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //       i  rw mtr mw  alu            wd             wr  instr          ack rdata         stray
    set_op(0, 1, 0, 0, 32'h0000_002A, 32'h0,        5,  32'h00A5_2020, 0, 32'h0,        0);
    set_op(1, 1, 1, 0, 32'h0000_0100, 32'h0,        8,  32'h8C08_0100, 3, 32'hDEAD_BEEF, -1);
    set_op(2, 1, 0, 1, 32'h0000_0204, 32'h1234_5678, 4, 32'hAC04_0204, 1, 32'h0,        2);
    set_op(3, 1, 1, 0, 32'h0000_0102, 32'h0,        9,  32'h8C09_0102, 0, 32'h0,        -1);
    set_op(4, 1, 1, 0, 32'h0000_0300, 32'h0,        11, 32'h8C0B_0300, 0, 32'h0,        -1);
    set_op(5, 1, 0, 0, 32'h0000_0055, 32'h0,        7,  32'h0107_3820, 0, 32'h0,        -1);
    set_op(6, 0, 0, 1, 32'h0000_0201, 32'hAAAA_5555, 0, 32'hAC00_0201, 0, 32'h0,        -1);
    set_op(7, 1, 1, 0, 32'h0000_0400, 32'h0,        10, 32'h8C0A_0400, 4, 32'hCAFE_F00D, -1);
    set_op(8, 1, 0, 0, 32'h0000_1000, 32'h0,        12, 32'h010C_6020, 0, 32'h0,        -1);
    build_model();

    // reset with a load waiting in EX/MEM: every output must stay 0
    regwriteM = 1; memtoregM = 1; aluoutM = 32'h100; writeregM = 8;
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stallM", 32'(stallM), 32'h0);
    chk("reset dmem_req", 32'(dmem_if.dmem_req), 32'h0);
    chk("reset regwriteW", 32'(regwriteW), 32'h0);
    chk("reset bus_err", 32'(bus_err), 32'h0);
    @(posedge clk); #1;
    rst = 0;

    for (int c = 0; c < ncyc; c++) begin
      apply(c);
      @(negedge clk);
      check_cycle(c);
      @(posedge clk); #1;
    end

    // hand-computed spot checks on the recorded run
    chk("alu regwriteW", 32'(o_rw[1]), 32'h1);
    chk("alu aluoutW", o_alu[1], 32'h0000_002A);
    chk("alu no stall", 32'(o_stall[0]), 32'h0);
    chk("lw stall cycles", 32'(count_hi(o_stall, 1, 5)), 32'd4);
    chk("lw req cycles", 32'(count_hi(o_req, 1, 5)), 32'd3);
    chk("lw readdataW", o_rd[6], 32'hDEAD_BEEF);
    chk("lw memtoregW", 32'(o_mtr[6]), 32'h1);
    chk("sw regwriteW", 32'(o_rw[9]), 32'h0);
    chk("misalign pulse", 32'(o_mis[10]), 32'h1);
    chk("misalign one cycle", 32'(o_mis[11]), 32'h0);
    chk("timeout req cycles", 32'(count_hi(o_req, 10, 15)), 32'd4);
    chk("bus_err set", 32'(o_bus[15]), 32'h1);
    chk("bus_err sticky", 32'(o_bus[27]), 32'h1);
    chk("alu after timeout", 32'(o_rw[17]), 32'h1);
    chk("last-cycle ack data", o_rd[24], 32'hCAFE_F00D);

    // reset during the second BUSY cycle of a load
    regwriteM = 1; memtoregM = 1; memwriteM = 0; aluoutM = 32'h500; writeregM = 3;
    instrM = 32'h8C03_0500; dmem_if.dmem_ack = 0;
    @(negedge clk);
    chk("rst-test issue stall", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    regwriteM = 0; memtoregM = 0; aluoutM = 0; writeregM = 0; instrM = 0;
    @(posedge clk); #1;
    rst = 0;
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("after rst dmem_req", 32'(dmem_if.dmem_req), 32'h0);
    chk("after rst stallM", 32'(stallM), 32'h0);
    chk("after rst regwriteW", 32'(regwriteW), 32'h0);
    chk("after rst instrW", instrW, 32'h0);
    chk("after rst bus_err", 32'(bus_err), 32'h0);
    @(posedge clk); #1;
    dmem_if.dmem_ack = 0;
    regwriteM = 1; aluoutM = 32'h99; writeregM = 6; instrM = 32'h0000_0099;
    @(negedge clk);
    chk("late ack readdataW", readdataW, 32'h0);
    chk("late ack memtoregW", 32'(memtoregW), 32'h0);
    chk("late ack dmem_req", 32'(dmem_if.dmem_req), 32'h0);
    chk("post-rst alu stall", 32'(stallM), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst alu regwriteW", 32'(regwriteW), 32'h1);
    chk("post-rst alu aluoutW", aluoutW, 32'h99);
    chk("post-rst alu writeregW", 32'(writeregW), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
